// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : Raster timing generator.
//            - Runs on the system clock.
//            - Advances only on cycles qualified by the one-cycle pixel
//              enable pulse from the pixel clock divider.
//            - Produces horizontal/vertical sync, the visible-area flag,
//              pixel coordinates, and line/frame start strobes.
//            - Defaults give 640x480@60 timing.
//            - Counters are 10 bits wide, so H_TOTAL and V_TOTAL must each
//              be <= 1024.
// Ports    : clock       - system clock
//            reset       - asynchronous, active-high reset
//            pixel_en    - one-clock pixel enable pulse
//            hsync       - horizontal sync, HS_POL level while active
//            vsync       - vertical sync, VS_POL level while active
//            video_on    - high while (pixel_x, pixel_y) is visible
//            pixel_x     - horizontal count, 0..H_TOTAL-1
//            pixel_y     - vertical count, 0..V_TOTAL-1
//            line_start  - one-clock strobe on entering pixel_x = 0
//            frame_start - one-clock strobe on entering (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixel_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Phase boundaries are kept one bit wider than the counters so that a
  // boundary equal to 1024 (zero-length back porch at maximum size) still
  // compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VIS);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VIS + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VIS);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VIS + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VIS + V_FP + V_SYNC);

  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic       hs_phase;
  logic       vs_phase;
  logic       vis_next;

  // Next-count computation and phase decode. The decode is taken from the
  // next counts so the registered sync/visible flags line up with the
  // counter values they describe, with no extra pipeline stage.
  always_comb begin
    x_wrap = (pixel_x == H_LAST);
    y_wrap = (pixel_y == V_LAST);
    x_next = x_wrap ? 10'd0 : pixel_x + 10'd1;
    y_next = pixel_y;
    if (x_wrap) begin
      y_next = y_wrap ? 10'd0 : pixel_y + 10'd1;
    end

    x_ext    = {1'b0, x_next};
    y_ext    = {1'b0, y_next};
    hs_phase = (x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END);
    vs_phase = (y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END);
    vis_next = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
  end

  // Reset parks the counters on the last position of the frame so that
  // the first enabled edge lands exactly on (0,0) and fires both strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes are single-clock: cleared every cycle unless re-armed by
      // an enabled edge that wraps the horizontal count.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_en) begin
        pixel_x     <= x_next;
        pixel_y     <= y_next;
        hsync       <= hs_phase ? HS_POL : ~HS_POL;
        vsync       <= vs_phase ? VS_POL : ~VS_POL;
        video_on    <= vis_next;
        line_start  <= x_wrap;
        frame_start <= x_wrap & y_wrap;
      end
    end
  end

endmodule
`default_nettype wire
